csr_file: RTL

- Parametrised machine-mode CSR file for the RV64 core; successor of the 4-register CSR block.
- Adds atomic CSRRW/CSRRS/CSRRC write ops, hardware trap entry and mret return, mcycle/minstret counters, and registered interrupt-pending bits.
- Feeds trap and interrupt decisions back to the clint/ex stages.
- Sits beside the EX stage: combinational read port to EX, one write port from EX, one trap/return port from clint.

---
 rtl/csr_file.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file: read/modify/write port from EX, trap entry and mret
// from clint, cycle/instret counters and registered interrupt-pending bits.
module csr_file #(
    parameter int unsigned      XLEN         = 64,
    parameter logic [XLEN-1:0]  MTVEC_RST    = XLEN'(64'ha00001800),
    parameter bit               HAS_COUNTERS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_raddr_i,
    output logic [XLEN-1:0] csr_rdata_o,
    input  logic [11:0]     csr_waddr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic [1:0]      csr_op_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            instret_i,
    input  logic            timer_irq_i,
    input  logic            ext_irq_i,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mstatus_o,
    output logic            irq_pending_o,
    output logic            illegal_o
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;

    logic            r_mie, r_mpie;
    logic [1:0]      r_mpp;
    logic            r_mtie, r_meie, r_mtip, r_meip;
    logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [XLEN-1:0] r_mcycle, r_minstret;

    logic [XLEN-1:0] w_mstatus, w_mie, w_mip, w_old, w_new;
    logic            w_impl, w_illegal, w_we;

    // Architectural views of the sparsely stored registers
    always_comb begin
        w_mstatus        = '0;
        w_mstatus[3]     = r_mie;
        w_mstatus[7]     = r_mpie;
        w_mstatus[12:11] = r_mpp;
        w_mie            = '0;
        w_mie[7]         = r_mtie;
        w_mie[11]        = r_meie;
        w_mip            = '0;
        w_mip[7]         = r_mtip;
        w_mip[11]        = r_meip;
    end

    function automatic logic [XLEN-1:0] read_csr(input logic [11:0] addr);
        logic [XLEN-1:0] v;
        v = '0;
        case (addr)
            A_MSTATUS:  v = w_mstatus;
            A_MIE:      v = w_mie;
            A_MTVEC:    v = r_mtvec;
            A_MSCRATCH: v = r_mscratch;
            A_MEPC:     v = r_mepc;
            A_MCAUSE:   v = r_mcause;
            A_MTVAL:    v = r_mtval;
            A_MIP:      v = w_mip;
            A_MCYCLE:   v = HAS_COUNTERS ? r_mcycle : '0;
            A_MINSTRET: v = HAS_COUNTERS ? r_minstret : '0;
            default:    v = '0;
        endcase
        return v;
    endfunction

    // Write-side decode and read-modify-write value
    always_comb begin
        w_old  = read_csr(csr_waddr_i);
        w_impl = 1'b0;
        case (csr_waddr_i)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MTVAL, A_MIP, A_MCYCLE, A_MINSTRET: w_impl = 1'b1;
            default:                              w_impl = 1'b0;
        endcase
        w_illegal = (csr_op_i != OP_NONE) && (!w_impl || (csr_waddr_i == A_MIP));
        w_we      = (csr_op_i != OP_NONE) && !w_illegal;
        case (csr_op_i)
            OP_WRITE: w_new = csr_wdata_i;
            OP_SET:   w_new = w_old | csr_wdata_i;
            default:  w_new = w_old & ~csr_wdata_i;
        endcase
    end

    assign csr_rdata_o   = rst ? read_csr(csr_raddr_i) : '0;
    assign illegal_o     = rst & w_illegal;
    assign irq_pending_o = rst & r_mie & ((r_mtip & r_mtie) | (r_meip & r_meie));
    assign mtvec_o       = r_mtvec;
    assign mepc_o        = r_mepc;
    assign mstatus_o     = w_mstatus;

    // Trap beats mret beats software write, but only on registers both touch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mpp      <= 2'b11;
            r_mtie     <= 1'b0;
            r_meie     <= 1'b0;
            r_mtip     <= 1'b0;
            r_meip     <= 1'b0;
            r_mtvec    <= MTVEC_RST;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            r_mtip <= timer_irq_i;
            r_meip <= ext_irq_i;

            if (trap_i) begin
                r_mpie <= r_mie;
                r_mie  <= 1'b0;
                r_mpp  <= 2'b11;
            end else if (mret_i) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
                r_mpp  <= 2'b11;
            end else if (w_we && csr_waddr_i == A_MSTATUS) begin
                r_mie  <= w_new[3];
                r_mpie <= w_new[7];
                r_mpp  <= w_new[12:11];
            end

            if (trap_i) begin
                r_mepc   <= trap_pc_i & ~XLEN'(3);
                r_mcause <= trap_cause_i;
                r_mtval  <= trap_tval_i;
            end else if (w_we) begin
                if (csr_waddr_i == A_MEPC)   r_mepc   <= w_new & ~XLEN'(3);
                if (csr_waddr_i == A_MCAUSE) r_mcause <= w_new;
                if (csr_waddr_i == A_MTVAL)  r_mtval  <= w_new;
            end

            if (w_we && csr_waddr_i == A_MIE) begin
                r_mtie <= w_new[7];
                r_meie <= w_new[11];
            end
            if (w_we && csr_waddr_i == A_MTVEC)    r_mtvec    <= w_new & ~XLEN'(2);
            if (w_we && csr_waddr_i == A_MSCRATCH) r_mscratch <= w_new;

            if (HAS_COUNTERS) begin
                if (w_we && csr_waddr_i == A_MCYCLE) r_mcycle <= w_new;
                else                                 r_mcycle <= r_mcycle + XLEN'(1);
                if (w_we && csr_waddr_i == A_MINSTRET) r_minstret <= w_new;
                else if (instret_i)                    r_minstret <= r_minstret + XLEN'(1);
            end
        end
    end

endmodule
